// File: rtl/awg_index_receiver.sv
// Serial index receiver for an AWG sequencer. Each frame carries a DS bit and
// then a preset (upper) or lower index field, and is committed by a load strobe.
module awg_index_receiver #(
  parameter int HI_BITS = 6,
  parameter int LO_BITS = 13
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sdata,
  input  logic                       shift,
  input  logic                       load,
  output logic [HI_BITS+LO_BITS-1:0] index,
  output logic                       index_valid,
  output logic [HI_BITS-1:0]         preset_hi,
  output logic                       frame_error,
  output logic                       busy
);

  typedef enum logic [2:0] {IDLE, SHIFT_HI, SHIFT_LO, FULL, ERR} state_t;

  localparam logic [4:0] HI_LAST = 5'(HI_BITS - 1);
  localparam logic [4:0] LO_LAST = 5'(LO_BITS - 1);

  state_t               state_reg;
  logic                 ds_reg;
  logic [4:0]           cnt_reg;
  // Sized for the wider lower field; a preset frame uses only its low bits.
  logic [LO_BITS-1:0]   shreg_reg;

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      ds_reg      <= 1'b0;
      cnt_reg     <= '0;
      shreg_reg   <= '0;
      preset_hi   <= '0;
      index       <= '0;
      index_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      index_valid <= 1'b0;
      frame_error <= 1'b0;
      // Load wins over a coincident shift; that shift bit is dropped.
      if (load) begin
        state_reg <= IDLE;
        if (state_reg == FULL) begin
          if (ds_reg) begin
            preset_hi <= shreg_reg[HI_BITS-1:0];
          end else begin
            index       <= {preset_hi, shreg_reg};
            index_valid <= 1'b1;
          end
        end else begin
          frame_error <= 1'b1;
        end
      end else if (shift) begin
        case (state_reg)
          IDLE: begin
            ds_reg    <= sdata;
            cnt_reg   <= '0;
            shreg_reg <= '0;
            state_reg <= sdata ? SHIFT_HI : SHIFT_LO;
          end
          SHIFT_HI, SHIFT_LO: begin
            shreg_reg <= {shreg_reg[LO_BITS-2:0], sdata};
            cnt_reg   <= cnt_reg + 5'd1;
            if (cnt_reg == ((state_reg == SHIFT_HI) ? HI_LAST : LO_LAST))
              state_reg <= FULL;
          end
          FULL:    state_reg <= ERR;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/awg_index_receiver.md
AWG_INDEX_RECEIVER -- requirements
Module: awg_index_receiver

Interface
REQ-001 The block SHALL have parameter HI_BITS, default 6, giving the preset (upper) index field width, i.e. index bits 18..13.
REQ-002 The block SHALL have parameter LO_BITS, default 13, giving the lower index field width, i.e. index bits 12..0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port sdata, input, 1 bit: serial data, sampled only when shift is high.
REQ-006 The block SHALL have port shift, input, 1 bit: one-cycle strobe that shifts in one sdata bit.
REQ-007 The block SHALL have port load, input, 1 bit: one-cycle latch strobe.
REQ-008 The block SHALL have port index, output, HI_BITS+LO_BITS bits: last committed sequencer index.
REQ-009 The block SHALL have port index_valid, output, 1 bit: one-cycle pulse on each index commit.
REQ-010 The block SHALL have port preset_hi, output, HI_BITS bits: preset register contents.
REQ-011 The block SHALL have port frame_error, output, 1 bit: one-cycle pulse on a malformed frame.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 Frame format SHALL be: first bit Data_Select (DS); then field bits MSB first; then a load strobe.
REQ-014 DS=1 SHALL select the preset field (HI_BITS bits); DS=0 SHALL select the lower field (LO_BITS bits).
REQ-015 The state machine SHALL have states IDLE, SHIFT_HI, SHIFT_LO, FULL and ERR.
REQ-016 In IDLE, shift SHALL capture DS: DS=1 -> SHIFT_HI, DS=0 -> SHIFT_LO, with the bit counter cleared.
REQ-017 In SHIFT_HI and SHIFT_LO, each shift SHALL left-shift sdata into the field shift register and increment the 5-bit bit counter.
REQ-018 When the counter reaches the field width (6 for SHIFT_HI, 13 for SHIFT_LO), the FSM SHALL go to FULL.
REQ-019 A shift while in FULL (overrun) SHALL move the FSM to ERR.
REQ-020 In ERR, further shifts SHALL be ignored.
REQ-021 Load in FULL with DS=1 SHALL copy the shift register into preset_hi, leave index unchanged, produce no index_valid, and return to IDLE.
REQ-022 Load in FULL with DS=0 SHALL set index = {preset_hi, shift register}, pulse index_valid for exactly one cycle, and return to IDLE.
REQ-023 index and index_valid SHALL be registered and appear in the cycle after the load edge, i.e. 1-cycle latency.
REQ-024 Load in IDLE, SHIFT_HI, SHIFT_LO or ERR (incomplete or overrun frame) SHALL pulse frame_error one cycle later, change no register, and return to IDLE.
REQ-025 When shift and load are high in the same cycle, load SHALL take priority and the coincident shift bit SHALL be discarded.
REQ-026 A DS=0 frame with no preceding DS=1 frame SHALL use the current preset_hi value (0 after reset).
REQ-027 preset_hi SHALL persist across any number of DS=0 frames until the next valid DS=1 frame.
REQ-028 index_valid and frame_error SHALL never be high in the same cycle.

Reset
REQ-029 rst high SHALL immediately force the FSM to IDLE and set the bit counter, shift register, preset_hi, index, index_valid and frame_error to 0, and busy to 0.
REQ-030 rst asserted mid-frame SHALL discard the partial frame.
REQ-031 The first DS bit after rst deasserts SHALL start a fresh frame.

Verification
REQ-032 Frame DS=1, bits 101101, load; then frame DS=0, bits 0000000000011, load -> preset_hi=6'h2D, then index=19'h5A003 with index_valid high for 1 cycle.
REQ-033 After reset, frame DS=0 with 13 ones, load -> index=19'h01FFF, index_valid pulses once.
REQ-034 DS=0 followed by only 5 bits, then load -> frame_error pulses once, index unchanged, busy=0 on the next cycle.
REQ-035 DS=1 followed by 7 bits (overrun), then load -> frame_error pulses, preset_hi unchanged.
REQ-036 Valid DS=0 frame with its 13th bit's shift and load in the same cycle -> load priority yields frame_error and no index update.
REQ-037 rst asserted after DS=1 and 3 bits -> all outputs 0 immediately; a following full DS=1 frame with bits 000001 -> preset_hi=6'h01.
